gbe_opb_cfg_master: RTL and testbench

OPB bus initiator that programs and verifies the GbE core's CPU-attach register bank without a processor. After reset (or on a start pulse) it writes the core's MAC, gateway, IP and port/enable/promiscuous registers from parameters. It then reads each register back and compares it with the written value. It reports done/error status to fabric logic, for designs that have no PowerPC/MicroBlaze or must bring the link up before software runs.

---
 rtl/gbe_opb_cfg_master.sv | 137 +++++++++++++
 tb/tb_gbe_opb_cfg_master.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gbe_opb_cfg_master.sv
// gbe_opb_cfg_master: OPB initiator that writes the GbE config registers from parameters, reads them back and reports done/error
module gbe_opb_cfg_master #(
  parameter logic [31:0] C_BASEADDR = 32'h0,
  parameter logic [47:0] CFG_MAC = 48'h0002_0304_0506,
  parameter logic [31:0] CFG_IP = 32'h0A00_0001,
  parameter logic [7:0] CFG_GATEWAY = 8'd1,
  parameter logic [15:0] CFG_PORT = 16'd10000,
  parameter logic CFG_ENABLE = 1'b1,
  parameter logic CFG_PROMISC = 1'b0,
  parameter bit AUTO_START = 1'b1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RETRY_MAX = 3
) (
  input logic OPB_Clk,
  input logic OPB_Rst,
  output logic M_select,
  output logic M_RNW,
  output logic [3:0] M_BE,
  output logic [31:0] M_ABus,
  output logic [31:0] M_DBus,
  input logic [31:0] Sl_DBus,
  input logic Sl_xferAck,
  input logic Sl_errAck,
  input logic Sl_retry,
  input logic start,
  output logic busy,
  output logic done,
  output logic error,
  output logic [1:0] err_code,
  output logic [3:0] err_index
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [3:0] idx, idx_n, retries, retries_n, err_index_n;
  logic [7:0] cnt, cnt_n, off;
  logic [3:0] be;
  logic [31:0] data;
  logic [2:0] slot;
  logic [1:0] err_code_n, fc;
  logic first, rd, active, done_n, error_n;
  assign rd = idx >= 4'd5;
  assign slot = 3'(rd ? idx - 4'd5 : idx);
  assign active = state == ISSUE || state == WAIT;
  assign M_select = active;
  assign M_RNW = !active || rd;
  assign M_BE = active ? be : 4'h0;
  assign M_ABus = active ? C_BASEADDR + {24'b0, off} : 32'h0;
  assign M_DBus = active && !rd ? data : 32'h0;
  assign busy = active || state == GAP;
  always_comb begin
    off = 8'h20;
    be = 4'hF;
    data = {7'b0, CFG_PROMISC, 7'b0, CFG_ENABLE, CFG_PORT};
    case (slot)
      3'd0: begin off = 8'h00; be = 4'h3; data = {16'b0, CFG_MAC[47:32]}; end
      3'd1: begin off = 8'h04; data = CFG_MAC[31:0]; end
      3'd2: begin off = 8'h0C; be = 4'h1; data = {24'b0, CFG_GATEWAY}; end
      3'd3: begin off = 8'h10; data = CFG_IP; end
      default: ;
    endcase
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    retries_n = retries;
    cnt_n = cnt;
    done_n = done;
    error_n = error;
    err_code_n = err_code;
    err_index_n = err_index;
    fc = 2'd0;
    case (state)
      IDLE, DONE, FAIL:
        if (start || (state == IDLE && first && AUTO_START)) begin
          state_n = ISSUE;
          idx_n = 4'd0;
          retries_n = 4'd0;
          done_n = 1'b0;
          error_n = 1'b0;
          err_code_n = 2'd0;
          err_index_n = 4'd0;
        end
      ISSUE: begin
        state_n = WAIT;
        cnt_n = 8'(TIMEOUT_CYCLES);
      end
      WAIT: begin
        cnt_n = cnt - 8'd1;
        if (Sl_errAck) fc = 2'd2;
        else if (Sl_xferAck && rd && Sl_DBus != data) fc = 2'd3;
        else if (Sl_xferAck) begin
          idx_n = idx + 4'd1;
          retries_n = 4'd0;
          state_n = idx == 4'd9 ? DONE : GAP;
          done_n = idx == 4'd9;
        end else if (Sl_retry) begin
          if (retries == 4'(RETRY_MAX)) fc = 2'd2;
          else begin
            retries_n = retries + 4'd1;
            state_n = GAP;
          end
        end else if (cnt <= 8'd1) fc = 2'd1;
      end
      GAP: state_n = ISSUE;
      default: state_n = IDLE;
    endcase
    if (fc != 2'd0) begin
      state_n = FAIL;
      error_n = 1'b1;
      err_code_n = fc;
      err_index_n = idx;
    end
  end
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state <= IDLE;
      idx <= 4'd0;
      retries <= 4'd0;
      cnt <= 8'd0;
      first <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= 2'd0;
      err_index <= 4'd0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      retries <= retries_n;
      cnt <= cnt_n;
      first <= 1'b0;
      done <= done_n;
      error <= error_n;
      err_code <= err_code_n;
      err_index <= err_index_n;
    end
  end
endmodule

// File: tb/tb_gbe_opb_cfg_master.sv
// tb_gbe_opb_cfg_master: scoreboard bench driving a scripted OPB slave against gbe_opb_cfg_master
module tb_gbe_opb_cfg_master;
  logic clk = 0, rst = 1, start = 0;
  logic sel, rnw, busy, done, error;
  logic [3:0] be, err_index;
  logic [1:0] err_code;
  logic [31:0] abus, dbus;
  logic [31:0] sl_dbus = 0;
  logic xack = 0, eack = 0, retry = 0;
  int n_cmp = 0, n_bad = 0;
  logic [68:0] sb[$];
  logic [68:0] obs[$];
  int hi = 0, lo = 0, last_hi = 0, cur_idx = 0;
  int sl_delay = 2, bad_idx = -1, err_idx = -1, retry_idx = -1, retry_left = 0;
  bit first_rise = 1;
  localparam logic [7:0] OFF[5] = '{8'h00, 8'h04, 8'h0C, 8'h10, 8'h20};
  localparam logic [3:0] BES[5] = '{4'h3, 4'hF, 4'h1, 4'hF, 4'hF};
  localparam logic [31:0] DAT[5] = '{32'h0000_0002, 32'h0304_0506, 32'h0000_0001, 32'h0A00_0001, 32'h0001_2710};
  gbe_opb_cfg_master dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .M_select(sel), .M_RNW(rnw), .M_BE(be), .M_ABus(abus), .M_DBus(dbus),
    .Sl_DBus(sl_dbus), .Sl_xferAck(xack), .Sl_errAck(eack), .Sl_retry(retry), .start(start),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [68:0] txn(input int i);
    int s = i % 5;
    logic r = i >= 5;
    return {r, BES[s], 24'b0, OFF[s], r ? 32'h0 : DAT[s]};
  endfunction
  task automatic push(input int a, input int b);
    for (int i = a; i <= b; i++) sb.push_back(txn(i));
  endtask
  task automatic cfg(input int d, input int bad, input int ei, input int ri, input int rn);
    sl_delay = d;
    bad_idx = bad;
    err_idx = ei;
    retry_idx = ri;
    retry_left = rn;
    first_rise = 1;
    sb.delete();
    obs.delete();
  endtask
  task automatic pulse();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic wait_end();
    for (int i = 0; i < 3000 && !(done || error); i++) @(negedge clk);
    chk("finish", 69'(done | error), 69'd1);
    chk("sb_left", 69'(sb.size()), 69'd0);
  endtask
  always begin
    @(posedge clk);
    #1;
    xack = 0;
    eack = 0;
    retry = 0;
    sl_dbus = $urandom;
    if (rst) begin
      hi = 0;
      lo = 0;
    end else if (sel) begin
      if (hi == 0) begin
        if (!first_rise) chk("gap", 69'(lo), 69'd1);
        first_rise = 0;
        lo = 0;
        obs.push_back({rnw, be, abus, dbus});
        if (sb.size() == 0) chk("sb_extra", 69'(sb.size()), 69'd1);
        else chk("txn", {rnw, be, abus, dbus}, sb.pop_front());
        cur_idx = rnw ? 5 : 0;
        for (int s = 0; s < 5; s++) if (OFF[s] == abus[7:0]) cur_idx += s;
      end
      hi++;
      if (hi == sl_delay) begin
        if (cur_idx == err_idx) begin
          eack = 1;
          xack = 1;
        end else if (cur_idx == retry_idx && retry_left > 0) begin
          retry = 1;
          retry_left--;
        end else begin
          xack = 1;
          sl_dbus = cur_idx < 5 ? 32'h0 : cur_idx == bad_idx ? 32'h0A00_0002 : DAT[cur_idx-5];
        end
      end
    end else begin
      if (hi != 0) last_hi = hi;
      hi = 0;
      lo++;
    end
  end
  initial begin
    cfg(2, -1, -1, -1, 0);
    push(0, 9);
    repeat (3) @(negedge clk);
    chk("rst_sel", 69'(sel), 69'd0);
    chk("rst_rnw", 69'(rnw), 69'd1);
    chk("rst_bus", {be, abus, dbus}, 69'd0);
    chk("rst_stat", {busy, done, error, err_code, err_index}, 69'd0);
    rst = 0;
    wait_end();
    chk("nom_done", 69'({done, error}), 69'b10);
    chk("nom_cnt", 69'(obs.size()), 69'd10);
    chk("t0_abus", 69'(obs[0][63:32]), 69'h0);
    chk("t0_dbus", 69'(obs[0][31:0]), 69'h2);
    chk("t0_be", 69'(obs[0][67:64]), 69'h3);
    chk("t4_dbus", 69'(obs[4][31:0]), 69'h0001_2710);
    cfg(20, -1, -1, -1, 0);
    push(0, 0);
    pulse();
    wait_end();
    chk("to_stat", {done, error, err_code, err_index}, 69'b0_1_01_0000);
    chk("to_sel", 69'(sel), 69'd0);
    chk("to_len", 69'(last_hi), 69'd17);
    cfg(2, 8, -1, -1, 0);
    push(0, 8);
    pulse();
    wait_end();
    chk("mm_stat", {done, error, err_code, err_index}, 69'b0_1_11_1000);
    cfg(2, -1, -1, 1, 4);
    push(0, 1);
    push(1, 1);
    push(1, 1);
    push(1, 1);
    pulse();
    wait_end();
    chk("rt4_stat", {done, error, err_code, err_index}, 69'b0_1_10_0001);
    cfg(2, -1, -1, 1, 3);
    push(0, 1);
    push(1, 1);
    push(1, 1);
    push(1, 9);
    pulse();
    repeat (15) @(negedge clk);
    chk("rt3_busy", 69'(busy), 69'd1);
    pulse();
    wait_end();
    chk("rt3_stat", {done, error, err_code, err_index}, 69'b1_0_00_0000);
    cfg(2, -1, 2, -1, 0);
    push(0, 2);
    pulse();
    wait_end();
    chk("ea_stat", {done, error, err_code, err_index}, 69'b0_1_10_0010);
    cfg(4, -1, -1, -1, 0);
    push(0, 6);
    pulse();
    for (int i = 0; i < 2000 && !(sel && cur_idx == 6 && hi == 2); i++) @(negedge clk);
    chk("reach6", 69'({sel, 4'(cur_idx)}), 69'b1_0110);
    rst = 1;
    @(negedge clk);
    chk("mr_sel", 69'({sel, rnw}), 69'b01);
    chk("mr_bus", {be, abus, dbus}, 69'd0);
    chk("mr_stat", {busy, done, error, err_code, err_index}, 69'd0);
    chk("mr_sb", 69'(sb.size()), 69'd0);
    cfg(2, -1, -1, -1, 0);
    push(0, 9);
    @(negedge clk) rst = 0;
    wait_end();
    chk("mr_done", 69'({done, error}), 69'b10);
    chk("mr_abus0", 69'(obs.size() > 0 ? obs[0][63:32] : 32'hFFFF_FFFF), 69'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
